// File: rtl/calc_pkg.sv
// Calculator-wide constants: keypad key indices, key-code width and the
// keypad scanner FSM state encoding.
package calc_pkg;

  localparam int KEY_W = 4;

  localparam logic [KEY_W-1:0] KEY_0   = 4'd0;
  localparam logic [KEY_W-1:0] KEY_1   = 4'd1;
  localparam logic [KEY_W-1:0] KEY_2   = 4'd2;
  localparam logic [KEY_W-1:0] KEY_3   = 4'd3;
  localparam logic [KEY_W-1:0] KEY_4   = 4'd4;
  localparam logic [KEY_W-1:0] KEY_5   = 4'd5;
  localparam logic [KEY_W-1:0] KEY_6   = 4'd6;
  localparam logic [KEY_W-1:0] KEY_7   = 4'd7;
  localparam logic [KEY_W-1:0] KEY_8   = 4'd8;
  localparam logic [KEY_W-1:0] KEY_9   = 4'd9;
  localparam logic [KEY_W-1:0] KEY_ADD = 4'd10;
  localparam logic [KEY_W-1:0] KEY_SUB = 4'd11;
  localparam logic [KEY_W-1:0] KEY_MUL = 4'd12;
  localparam logic [KEY_W-1:0] KEY_EQ  = 4'd13;
  localparam logic [KEY_W-1:0] KEY_CLR = 4'd14;
  localparam logic [KEY_W-1:0] KEY_NEG = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_EVAL
  } scan_state_t;

endpackage

// File: rtl/input_sr_scanner.sv
// Drives a 74HC165-style parallel-in/serial-out chain and returns one raw
// (1 = pressed) key vector per scan, flagged by a one-cycle scan_done.
//
// state       | meaning
// ST_IDLE     | single cycle after reset, before the first scan
// ST_LOAD     | load_n low, chain captures the key levels
// ST_SHIFT_LO | sr_clk low; data sampled on the last cycle
// ST_SHIFT_HI | sr_clk high; chain presents the next bit
// ST_EVAL     | raw vector complete, scan_done asserted
module input_sr_scanner
  import calc_pkg::*;
#(
  parameter int NUM_KEYS = 16,
  parameter int CLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_sr_data,
  output logic                o_sr_clk,
  output logic                o_sr_load_n,
  output logic [NUM_KEYS-1:0] raw,
  output logic                scan_done
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int BW = $clog2(NUM_KEYS + 1);

  scan_state_t   state, state_next;
  logic [TW-1:0] tmr;
  logic          tmr_tc;
  logic [BW-1:0] bits_left;
  logic [1:0]    sync;
  logic          sample;

  assign tmr_tc    = (tmr == '0);
  assign sample    = (state == ST_SHIFT_LO) && tmr_tc;
  assign scan_done = (state == ST_EVAL);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     state_next = ST_LOAD;
      ST_LOAD:     if (tmr_tc) state_next = ST_SHIFT_LO;
      ST_SHIFT_LO: if (tmr_tc) state_next = ST_SHIFT_HI;
      ST_SHIFT_HI: if (tmr_tc) state_next = (bits_left == '0) ? ST_EVAL : ST_SHIFT_LO;
      ST_EVAL:     state_next = ST_LOAD;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Pins are registered from the next state so they never glitch on decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tmr         <= '0;
      bits_left   <= '0;
      sync        <= 2'b11;
      raw         <= '0;
      o_sr_clk    <= 1'b0;
      o_sr_load_n <= 1'b1;
    end else begin
      state       <= state_next;
      tmr         <= (state_next != state) ? TW'(CLK_DIV - 1) : tmr - TW'(1);
      sync        <= {sync[0], i_sr_data};
      o_sr_clk    <= (state_next == ST_SHIFT_HI);
      o_sr_load_n <= (state_next != ST_LOAD);
      if (state == ST_LOAD)
        bits_left <= BW'(NUM_KEYS);
      else if (sample)
        bits_left <= bits_left - BW'(1);
      if (sample)
        raw <= {raw[NUM_KEYS-2:0], ~sync[1]};
    end
  end

endmodule

// File: rtl/input_driver.sv
// Keypad front end: debounces scanner output and hands one key code per new
// press to the core. INPUT_DRIVER_AUTOREPEAT_EN adds held-key auto-repeat.
module input_driver
  import calc_pkg::*;
#(
  parameter int NUM_KEYS       = 16,
  parameter int CLK_DIV        = 4,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_sr_data,
  output logic                        o_sr_clk,
  output logic                        o_sr_load_n,
  output logic [$clog2(NUM_KEYS)-1:0] o_key,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_dropped
);

  localparam int KW = $clog2(NUM_KEYS);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);

  logic [NUM_KEYS-1:0] raw, last_raw, debounced, deb_next, new_press;
  logic [SW-1:0]       stable, stable_next;
  logic [KW-1:0]       new_key, ev_key;
  logic                scan_done, new_any, ev;

  input_sr_scanner #(
    .NUM_KEYS (NUM_KEYS),
    .CLK_DIV  (CLK_DIV)
  ) u_scanner (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sr_data   (i_sr_data),
    .o_sr_clk    (o_sr_clk),
    .o_sr_load_n (o_sr_load_n),
    .raw         (raw),
    .scan_done   (scan_done)
  );

  always_comb begin
    stable_next = SW'(1);
    if (raw == last_raw)
      stable_next = (stable == SW'(DEBOUNCE_SCANS)) ? stable : stable + SW'(1);
    deb_next  = (stable_next == SW'(DEBOUNCE_SCANS)) ? raw : debounced;
    new_press = deb_next & ~debounced;
    new_key   = '0;
    // Downward scan so the lowest newly pressed index wins.
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (new_press[i]) new_key = KW'(i);
  end

  assign new_any = |new_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_raw  <= '0;
      stable    <= '0;
      debounced <= '0;
    end else if (scan_done) begin
      last_raw  <= raw;
      stable    <= stable_next;
      debounced <= deb_next;
    end
  end

`ifdef INPUT_DRIVER_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_SCANS + 1);

  logic [RW-1:0] rep_tmr;
  logic [KW-1:0] rep_key, held_key;
  logic          rep_armed, held_any, rep_fire;

  always_comb begin
    held_key = '0;
    held_any = |debounced;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (debounced[i]) held_key = KW'(i);
  end

  assign rep_fire = scan_done && rep_armed && (deb_next == debounced) &&
                    held_any && (held_key == rep_key) && (rep_tmr == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_tmr   <= '0;
      rep_key   <= '0;
      rep_armed <= 1'b0;
    end else if (scan_done) begin
      if (deb_next != debounced) begin
        rep_tmr <= RW'(REPEAT_SCANS - 1);
        if (new_any) begin
          rep_key   <= new_key;
          rep_armed <= 1'b1;
        end
      end else if (rep_tmr == '0) begin
        rep_tmr <= RW'(REPEAT_SCANS - 1);
      end else begin
        rep_tmr <= rep_tmr - RW'(1);
      end
    end
  end

  assign ev     = scan_done && (new_any || rep_fire);
  assign ev_key = new_any ? new_key : rep_key;
`else
  logic unused_rep;
  assign unused_rep = (REPEAT_SCANS != 0);
  assign ev         = scan_done && new_any;
  assign ev_key     = new_key;
`endif

  // Single-entry slot; a same-cycle accept frees it for the incoming key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid   <= 1'b0;
      o_key     <= '0;
      o_dropped <= 1'b0;
    end else begin
      o_dropped <= 1'b0;
      if (ev) begin
        if (!o_valid || i_ready) begin
          o_valid <= 1'b1;
          o_key   <= ev_key;
        end else begin
          o_dropped <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_input_driver.sv
// Bench for input_driver: external shift-register model, scan-level
// reference model with per-cycle compare, and directed plus random keys.
module tb_input_driver;

  localparam int N      = 16;
  localparam int CD     = 4;
  localparam int DEB    = 4;
  localparam int PERIOD = CD + 2 * CD * N + 1;
  localparam int KW     = $clog2(N);
  localparam int TICK   = 60;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_ready = 1'b1;
  logic          i_sr_data;
  logic          o_sr_clk, o_sr_load_n, o_valid, o_dropped;
  logic [KW-1:0] o_key;

  logic [N-1:0]  keys = '0;
  logic [N-1:0]  sr = '1;
  logic          sr_clk_prev = 1'b0;
  bit            rand_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  input_driver #(
    .NUM_KEYS       (N),
    .CLK_DIV        (CD),
    .DEBOUNCE_SCANS (DEB),
    .REPEAT_SCANS   (64)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_sr_data   (i_sr_data),
    .o_sr_clk    (o_sr_clk),
    .o_sr_load_n (o_sr_load_n),
    .o_key       (o_key),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_dropped   (o_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // 74HC165 model: parallel load while load_n low, shift on sr_clk rise.
  assign i_sr_data = sr[N-1];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr          <= '1;
      sr_clk_prev <= 1'b0;
    end else begin
      sr_clk_prev <= o_sr_clk;
      if (!o_sr_load_n)
        sr <= ~keys;
      else if (o_sr_clk && !sr_clk_prev)
        sr <= {sr[N-2:0], 1'b1};
    end
  end

  // Reference model: cycle phase from reset, scan history, debounce and slot.
  int           k = 0;
  int           phase = -1;
  int           exp_key = 0;
  int           ek;
  bit           exp_valid = 1'b0, exp_drop = 1'b0;
  bit           exp_load_n = 1'b1, exp_sr_clk = 1'b0;
  bit           acc, ev, same;
  logic [N-1:0] cap = '0, deb = '0, nd, nw;
  logic [N-1:0] hist[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; phase = -1; exp_key = 0;
      exp_valid = 0; exp_drop = 0; exp_load_n = 1; exp_sr_clk = 0;
      cap = '0; deb = '0;
      hist.delete();
    end else begin
      k++;
      phase = (k - 1) % PERIOD;
      acc = exp_valid && i_ready;
      exp_drop = 0; ev = 0; ek = 0;
      if (phase == 0 && k > 1) begin
        hist.push_back(cap);
        if (hist.size() > DEB) void'(hist.pop_front());
        same = (hist.size() == DEB);
        foreach (hist[j]) if (hist[j] != cap) same = 0;
        nd = same ? cap : deb;
        nw = nd & ~deb;
        deb = nd;
        for (int i = N - 1; i >= 0; i--) if (nw[i]) begin ev = 1; ek = i; end
      end
      if (phase == 2) cap = keys;
      if (ev) begin
        if (!exp_valid || acc) begin exp_valid = 1; exp_key = ek; end
        else exp_drop = 1;
      end else if (acc) begin
        exp_valid = 0;
      end
      exp_load_n = !(phase < CD);
      exp_sr_clk = (phase >= CD) && (phase < CD + 2 * CD * N) && (((phase - CD) / CD) % 2 == 1);
    end
  end

  always @(negedge clk) begin
    check("sr_load_n", o_sr_load_n, exp_load_n);
    check("sr_clk", o_sr_clk, exp_sr_clk);
    check("valid", o_valid, exp_valid);
    check("key", o_key, exp_key);
    check("dropped", o_dropped, exp_drop);
  end

  // Observed traffic, used for the hand-computed expectations.
  int   acc_q[$];
  int   drop_cnt = 0, rises = 0, last_rises = 0, per = 0, last_per = 0;
  logic mon_load_prev = 1'b1, mon_clk_prev = 1'b0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (o_valid && i_ready) acc_q.push_back(int'(o_key));
      if (o_dropped) drop_cnt++;
      per++;
      if (o_sr_clk && !mon_clk_prev) rises++;
      if (!o_sr_load_n && mon_load_prev) begin
        last_rises = rises; rises = 0;
        last_per = per; per = 0;
      end
      mon_clk_prev  = o_sr_clk;
      mon_load_prev = o_sr_load_n;
    end
  end

  function automatic int first_after(input int b);
    return (acc_q.size() > b) ? acc_q[b] : -1;
  endfunction

  task automatic wait_scan();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
      if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
    end while (phase != TICK && g < 2 * PERIOD);
    if (phase != TICK) check("scan_tick", phase, TICK);
  endtask

  task automatic set_keys(input logic [N-1:0] v, input int n);
    wait_scan();
    keys = v;
    repeat (n - 1) wait_scan();
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int           base, dbase, g;
    logic [N-1:0] v, prevv;
    logic [N-1:0] one;
    one = 1;

    repeat (3) @(negedge clk);
    check("rst_load_n", o_sr_load_n, 1);
    check("rst_sr_clk", o_sr_clk, 0);
    check("rst_valid", o_valid, 0);
    check("rst_key", o_key, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_load", o_sr_load_n, 0);

    base = acc_q.size();
    set_keys('0, 3);
    check("idle_events", acc_q.size() - base, 0);
    check("sr_clk_rises", last_rises, N);
    check("scan_period", last_per, PERIOD);

    base = acc_q.size();
    set_keys(one << 5, 6);
    set_keys('0, 4);
    check("k5_count", acc_q.size() - base, 1);
    check("k5_key", first_after(base), 5);

    base = acc_q.size();
    set_keys(one << 9, 1);
    set_keys('0, 1);
    set_keys(one << 9, 6);
    set_keys('0, 4);
    check("k9_count", acc_q.size() - base, 1);
    check("k9_key", first_after(base), 9);

    base = acc_q.size();
    set_keys((one << 3) | (one << 12), 6);
    set_keys('0, 4);
    check("k3_12_count", acc_q.size() - base, 1);
    check("k3_12_key", first_after(base), 3);

    i_ready = 1'b0;
    base  = acc_q.size();
    dbase = drop_cnt;
    set_keys(one << 2, 6);
    set_keys('0, 6);
    set_keys(one << 7, 6);
    set_keys('0, 2);
    check("held_valid", o_valid, 1);
    check("held_key", o_key, 2);
    check("drop_count", drop_cnt - dbase, 1);
    check("no_accept", acc_q.size() - base, 0);
    i_ready = 1'b1;
    @(negedge clk);
    check("valid_falls", o_valid, 0);
    check("accepted_key", first_after(base), 2);
    set_keys('0, 4);

    rand_ready = 1'b1;
    prevv = '0;
    for (int s = 0; s < 30; s++) begin
      case ($urandom_range(0, 3))
        0:       v = '0;
        1:       v = one << $urandom_range(0, N - 1);
        2:       v = N'($urandom) & N'($urandom);
        default: v = prevv;
      endcase
      prevv = v;
      set_keys(v, $urandom_range(1, 6));
    end
    rand_ready = 1'b0;
    i_ready = 1'b1;
    set_keys('0, 5);

    i_ready = 1'b0;
    set_keys(one << 1, 6);
    g = 0;
    while (!o_valid && g < 2 * PERIOD) begin @(negedge clk); g++; end
    check("pre_rst_valid", o_valid, 1);
    g = 0;
    while (!o_sr_clk && g < 4 * CD) begin @(negedge clk); g++; end
    check("pre_rst_shift_hi", o_sr_clk, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_sr_clk", o_sr_clk, 0);
    check("async_load_n", o_sr_load_n, 1);
    check("async_valid", o_valid, 0);
    check("async_key", o_key, 0);
    keys = '0;
    i_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_load", o_sr_load_n, 0);
    repeat (2 * PERIOD) @(negedge clk);
    check("restart_period", last_per, PERIOD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
